// File: rtl/result_drain_pkg.sv
// -----------------------------------------------------------------------------
// result_drain_pkg
// Shared types and constants for the result drain stage.
//   drain_state_t : drain sequencer states
//   DEF_*         : default build parameters of result_drain
//   CSUM_W        : checksum width of the default build
// -----------------------------------------------------------------------------
package result_drain_pkg;

  localparam int DEF_NUM_RESULTS = 16;
  localparam int DEF_DATA_W      = 9;

  // Wide enough that a full drain of maximal words never wraps.
  localparam int CSUM_W = DEF_DATA_W + $clog2(DEF_NUM_RESULTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RY = 2'd2,
    FLUSH   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Show-ahead FIFO buffering drained result words.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   push       : write push_data (ignored when full and not popping)
//   push_data  : word to store
//   pop        : remove head (ignored when empty)
//   head       : current head word, zero while empty
//   empty/full : occupancy flags
//   count      : number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module result_fifo
  import result_drain_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Occupancy flags, qualified push/pop and the show-ahead head word.
  always_comb begin
    empty     = (count_r == {CNT_W{1'b0}});
    full      = (count_r == DEPTH_CNT);
    count     = count_r;
    do_pop_s  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    do_push_s = push & (~full | do_pop_s);
    if (empty) begin
      head = {DATA_W{1'b0}};
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
// Reads NUM_RESULTS words from the matrix core's result memory after the core
// raises finish_in, buffers them in a FIFO and presents them on a valid/ready
// stream while accumulating a checksum.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   finish_in           : core done level; a 0->1 edge starts a drain
//   read_n, r_addr      : active-low read strobe and address to the core
//   ry, data_in         : core read-ready and read data
//   out_data, out_valid : FIFO head and non-empty flag
//   out_ready           : sink accepts out_data
//   busy                : drain in progress
//   drain_done          : one-cycle completion pulse
//   checksum            : modular sum of the words of the current/last drain
// -----------------------------------------------------------------------------
module result_drain
  import result_drain_pkg::*;
#(
  parameter  int NUM_RESULTS = DEF_NUM_RESULTS,
  parameter  int ADDR_W      = 8,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int FIFO_DEPTH  = 4,
  // Default build shares the package constant; other builds derive it here.
  localparam int CS_W        = (NUM_RESULTS == DEF_NUM_RESULTS && DATA_W == DEF_DATA_W)
                               ? CSUM_W : DATA_W + $clog2(NUM_RESULTS),
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish_in,
  output logic              read_n,
  output logic [ADDR_W-1:0] r_addr,
  input  logic              ry,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              drain_done,
  output logic [CS_W-1:0]   checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_RESULTS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  drain_state_t      state_r;
  drain_state_t      state_next_s;
  logic              finish_prev_r;
  logic [ADDR_W-1:0] idx_r;
  logic [CS_W-1:0]   csum_r;
  logic              busy_r;
  logic              done_r;

  logic              rise_s;
  logic              start_s;
  logic              capture_s;
  logic              complete_s;

  logic              fifo_push_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [CNT_W-1:0]  fifo_count_s;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (data_in),
    .pop       (out_ready),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  assign out_data   = fifo_head_s;
  assign out_valid  = ~fifo_empty_s;
  assign r_addr     = idx_r;
  assign busy       = busy_r;
  assign drain_done = done_r;
  assign checksum   = csum_r;

  // Next-state decode plus the read strobe and per-cycle control events.
  always_comb begin
    state_next_s = state_r;
    read_n       = 1'b1;
    start_s      = 1'b0;
    capture_s    = 1'b0;
    complete_s   = 1'b0;
    rise_s       = finish_in & ~finish_prev_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          start_s      = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        // Only issue when a slot is guaranteed for the returning word.
        if (fifo_count_s < DEPTH_CNT) begin
          read_n       = 1'b0;
          state_next_s = WAIT_RY;
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAIT_RY: begin
        if (ry) begin
          capture_s = 1'b1;
          if (idx_r < LAST_IDX) begin
            state_next_s = ISSUE;
          end else begin
            state_next_s = FLUSH;
          end
        end else begin
          state_next_s = WAIT_RY;
        end
      end
      FLUSH: begin
        if (fifo_empty_s) begin
          complete_s   = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    fifo_push_s = capture_s & ~fifo_full_s;
  end

  // Sequencer state, edge history, address counter, checksum and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      // Loading the live level means a finish_in already high at release is not an edge.
      finish_prev_r <= finish_in;
      idx_r         <= {ADDR_W{1'b0}};
      csum_r        <= {CS_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      finish_prev_r <= finish_in;
      done_r        <= complete_s;
      if (start_s) begin
        idx_r  <= {ADDR_W{1'b0}};
        csum_r <= {CS_W{1'b0}};
        busy_r <= 1'b1;
      end else if (capture_s) begin
        idx_r  <= idx_r + ADDR_W'(1'b1);
        csum_r <= csum_r + CS_W'(data_in);
      end else if (complete_s) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
// Self-checking bench for result_drain. A core model answers each read after a
// configurable delay from a word array; a sink drives out_ready. The expected
// stream is simply the array in address order and the expected checksum its
// modular sum.
// -----------------------------------------------------------------------------
module tb_result_drain;

  localparam int NUM_RESULTS = 16;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 9;
  localparam int FIFO_DEPTH  = 4;
  localparam int CSUM_W      = DATA_W + $clog2(NUM_RESULTS);

  logic              clk;
  logic              rst;
  logic              finish_in;
  logic              read_n;
  logic [ADDR_W-1:0] r_addr;
  logic              ry;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              drain_done;
  logic [CSUM_W-1:0] checksum;

  result_drain #(
    .NUM_RESULTS (NUM_RESULTS),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .finish_in  (finish_in),
    .read_n     (read_n),
    .r_addr     (r_addr),
    .ry         (ry),
    .data_in    (data_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .drain_done (drain_done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // core model / sink configuration
  logic [DATA_W-1:0] core_mem [NUM_RESULTS];
  int  delay_min  = 1;
  int  delay_max  = 1;
  int  ready_mode = 0;   // 0 always ready, 1 never ready, 2 random
  bit  spur_ry    = 1'b0;

  // observations
  logic [ADDR_W-1:0] issued [$];
  logic [DATA_W-1:0] popped [$];
  int  done_cnt, served_cnt, multi_err, hold_err, cyc;
  int  fin_rise_cyc, busy_rise_cyc, first_read_cyc, done_cyc;
  bit  pending;
  int  wait_cnt;
  logic [ADDR_W-1:0] pend_addr;
  logic prev_busy, prev_fin;

  // Drives core/sink inputs at negedge+1 and samples the DUT at negedge+2.
  initial begin : env
    ry = 1'b0; data_in = '0; out_ready = 1'b0;
    pending = 1'b0; wait_cnt = 0; pend_addr = '0; cyc = 0;
    prev_busy = 1'b0; prev_fin = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (pending && wait_cnt == 0) begin
        ry = 1'b1; data_in = core_mem[pend_addr]; pending = 1'b0; served_cnt++;
      end else begin
        ry = spur_ry ? 1'($urandom_range(1, 0)) : 1'b0;
        data_in = DATA_W'($urandom);
        if (pending) wait_cnt--;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      #1;
      cyc++;
      if (!rst) begin
        if (read_n == 1'b0) begin
          if (pending) multi_err++;
          if (first_read_cyc < 0) first_read_cyc = cyc;
          issued.push_back(r_addr);
          pending = 1'b1; pend_addr = r_addr;
          wait_cnt = int'($urandom_range(delay_max, delay_min)) - 1;
        end else if (pending && r_addr !== pend_addr) begin
          hold_err++;
        end
        if (out_valid && out_ready) popped.push_back(out_data);
        if (drain_done) begin done_cnt++; done_cyc = cyc; end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (finish_in && !prev_fin) fin_rise_cyc = cyc;
      end else begin
        pending = 1'b0;
      end
      prev_busy = busy; prev_fin = finish_in;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural checksum: plain modular sum of the memory contents.
  function automatic logic [CSUM_W-1:0] model_sum();
    longint s = 0;
    for (int i = 0; i < NUM_RESULTS; i++) s += core_mem[i];
    return CSUM_W'(s % (longint'(1) << CSUM_W));
  endfunction

  task automatic clear_env();
    issued.delete(); popped.delete();
    done_cnt = 0; served_cnt = 0; multi_err = 0; hold_err = 0;
    fin_rise_cyc = -1; busy_rise_cyc = -1; first_read_cyc = -1; done_cyc = -1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_RESULTS; i++) core_mem[i] = DATA_W'($urandom);
  endtask

  task automatic start_drain();
    @(negedge clk); #1;
    finish_in = 1'b1;
  endtask

  task automatic end_drain();
    @(negedge clk); #1;
    finish_in = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    check_cnt++;
    if (done_cnt == 0) $display("FAIL %s_timeout: drain_done not seen within %0d cycles", name, budget);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; finish_in = 1'b0;
    clear_env();
    repeat (3) @(negedge clk);
    #3;
    check_cnt++; if (read_n !== 1'b1) $display("FAIL reset_read_n: got %b want 1", read_n); else pass_cnt++;
    check_cnt++; if (r_addr !== '0) $display("FAIL reset_r_addr: got %0d want 0", r_addr); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %0d want 0", out_data); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (drain_done !== 1'b0) $display("FAIL reset_drain_done: got %b want 0", drain_done); else pass_cnt++;
    check_cnt++; if (checksum !== '0) $display("FAIL reset_checksum: got %0d want 0", checksum); else pass_cnt++;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < NUM_RESULTS; i++) core_mem[i] = DATA_W'(i + 3);
    delay_min = 1; delay_max = 1; ready_mode = 0;
    @(negedge clk); #1;
    clear_env();
    start_drain();
    wait_done("basic", 200);
    check_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (checksum !== CSUM_W'(168)) $display("FAIL basic_checksum: got %0d want 168", checksum); else pass_cnt++;
    check_cnt++; if (busy_rise_cyc - fin_rise_cyc !== 1) $display("FAIL basic_start_latency: got %0d want 1", busy_rise_cyc - fin_rise_cyc); else pass_cnt++;
    check_cnt++; if (first_read_cyc !== busy_rise_cyc) $display("FAIL basic_first_read: got cycle %0d want %0d", first_read_cyc, busy_rise_cyc); else pass_cnt++;
    check_cnt++; if (done_cyc - busy_rise_cyc !== 2 * NUM_RESULTS + 2) $display("FAIL basic_drain_time: got %0d want %0d", done_cyc - busy_rise_cyc, 2 * NUM_RESULTS + 2); else pass_cnt++;
    check_cnt++; if (issued.size() !== NUM_RESULTS || popped.size() !== NUM_RESULTS) $display("FAIL basic_counts: got %0d reads %0d words want %0d", issued.size(), popped.size(), NUM_RESULTS); else pass_cnt++;
    for (int i = 0; i < NUM_RESULTS && i < issued.size() && i < popped.size(); i++) begin
      check_cnt++;
      if (issued[i] !== ADDR_W'(i) || popped[i] !== DATA_W'(i + 3))
        $display("FAIL basic_word%0d: got addr %0d data %0d want addr %0d data %0d", i, issued[i], popped[i], i, i + 3);
      else pass_cnt++;
    end
    end_drain();
  endtask

  task automatic test_spurious();
    int vbad = 0;
    logic [CSUM_W-1:0] prev_sum;
    prev_sum = model_sum();
    @(negedge clk); #1;
    clear_env();
    spur_ry = 1'b1;
    repeat (8) begin @(negedge clk); #3; if (out_valid !== 1'b0 || busy !== 1'b0) vbad++; end
    @(negedge clk); #1;
    spur_ry = 1'b0;
    #2;
    check_cnt++; if (vbad !== 0) $display("FAIL spur_idle_ry: got %0d cycles with valid/busy want 0", vbad); else pass_cnt++;
    check_cnt++; if (popped.size() !== 0 || issued.size() !== 0) $display("FAIL spur_idle_activity: got %0d words %0d reads want 0", popped.size(), issued.size()); else pass_cnt++;
    check_cnt++; if (checksum !== prev_sum) $display("FAIL spur_idle_checksum: got %0d want %0d", checksum, prev_sum); else pass_cnt++;
    fill_random();
    delay_min = 1; delay_max = 3; ready_mode = 2;
    start_drain();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin @(negedge clk); #1; finish_in = ~finish_in; end
    wait_done("spur", 400);
    repeat (10) @(negedge clk);
    #3;
    check_cnt++; if (done_cnt !== 1) $display("FAIL spur_restart: got %0d done pulses want 1", done_cnt); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || issued.size() !== NUM_RESULTS) $display("FAIL spur_reads: got busy %b reads %0d want 0/%0d", busy, issued.size(), NUM_RESULTS); else pass_cnt++;
    check_cnt++; if (checksum !== model_sum()) $display("FAIL spur_checksum: got %0d want %0d", checksum, model_sum()); else pass_cnt++;
    check_cnt++; if (popped.size() !== NUM_RESULTS) $display("FAIL spur_word_count: got %0d want %0d", popped.size(), NUM_RESULTS); else pass_cnt++;
    for (int i = 0; i < NUM_RESULTS && i < popped.size(); i++) begin
      check_cnt++;
      if (popped[i] !== core_mem[i]) $display("FAIL spur_word%0d: got %0d want %0d", i, popped[i], core_mem[i]); else pass_cnt++;
    end
    end_drain();
  endtask

  task automatic test_backpressure();
    fill_random();
    delay_min = 1; delay_max = 1; ready_mode = 1;
    @(negedge clk); #1;
    clear_env();
    start_drain();
    repeat (20) @(negedge clk);
    #3;
    check_cnt++; if (issued.size() !== FIFO_DEPTH) $display("FAIL bp_reads_stalled: got %0d want %0d", issued.size(), FIFO_DEPTH); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b1 || popped.size() !== 0) $display("FAIL bp_held: got valid %b words %0d want 1/0", out_valid, popped.size()); else pass_cnt++;
    ready_mode = 2;
    wait_done("bp", 400);
    check_cnt++; if (issued.size() !== NUM_RESULTS || popped.size() !== NUM_RESULTS) $display("FAIL bp_counts: got %0d reads %0d words want %0d", issued.size(), popped.size(), NUM_RESULTS); else pass_cnt++;
    for (int i = 0; i < NUM_RESULTS && i < issued.size() && i < popped.size(); i++) begin
      check_cnt++;
      if (issued[i] !== ADDR_W'(i) || popped[i] !== core_mem[i])
        $display("FAIL bp_word%0d: got addr %0d data %0d want addr %0d data %0d", i, issued[i], popped[i], i, core_mem[i]);
      else pass_cnt++;
    end
    check_cnt++; if (checksum !== model_sum()) $display("FAIL bp_checksum: got %0d want %0d", checksum, model_sum()); else pass_cnt++;
    end_drain();
  endtask

  task automatic test_slow_core();
    fill_random();
    delay_min = 5; delay_max = 5; ready_mode = 2;
    @(negedge clk); #1;
    clear_env();
    start_drain();
    wait_done("slow", 600);
    check_cnt++; if (multi_err !== 0) $display("FAIL slow_read_strobe: got %0d repeated/overlapping strobes want 0", multi_err); else pass_cnt++;
    check_cnt++; if (hold_err !== 0) $display("FAIL slow_addr_hold: got %0d unstable cycles want 0", hold_err); else pass_cnt++;
    check_cnt++; if (issued.size() !== NUM_RESULTS || popped.size() !== NUM_RESULTS) $display("FAIL slow_counts: got %0d reads %0d words want %0d", issued.size(), popped.size(), NUM_RESULTS); else pass_cnt++;
    for (int i = 0; i < NUM_RESULTS && i < issued.size() && i < popped.size(); i++) begin
      check_cnt++;
      if (issued[i] !== ADDR_W'(i) || popped[i] !== core_mem[i])
        $display("FAIL slow_word%0d: got addr %0d data %0d want addr %0d data %0d", i, issued[i], popped[i], i, core_mem[i]);
      else pass_cnt++;
    end
    check_cnt++; if (checksum !== model_sum()) $display("FAIL slow_checksum: got %0d want %0d", checksum, model_sum()); else pass_cnt++;
    end_drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_random();
    delay_min = 1; delay_max = 2; ready_mode = 2;
    @(negedge clk); #1;
    clear_env();
    start_drain();
    while (served_cnt < 7 && n < 200) begin @(negedge clk); #3; n++; end
    check_cnt++; if (served_cnt < 7) $display("FAIL rmid_progress: got %0d words want 7", served_cnt); else pass_cnt++;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    #2;
    check_cnt++;
    if (read_n !== 1'b1 || r_addr !== '0 || out_valid !== 1'b0 || out_data !== '0 ||
        busy !== 1'b0 || drain_done !== 1'b0 || checksum !== '0)
      $display("FAIL rmid_reset_values: got read_n %b addr %0d valid %b data %0d busy %b done %b csum %0d want 1/0/0/0/0/0/0",
               read_n, r_addr, out_valid, out_data, busy, drain_done, checksum);
    else pass_cnt++;
    @(negedge clk); #1;
    clear_env();
    repeat (6) @(negedge clk);
    #3;
    check_cnt++; if (busy !== 1'b0 || issued.size() !== 0) $display("FAIL rmid_no_resume: got busy %b reads %0d want 0/0", busy, issued.size()); else pass_cnt++;
    end_drain();
    clear_env();
    start_drain();
    wait_done("rmid", 400);
    check_cnt++; if (issued.size() !== NUM_RESULTS || popped.size() !== NUM_RESULTS) $display("FAIL rmid_counts: got %0d reads %0d words want %0d", issued.size(), popped.size(), NUM_RESULTS); else pass_cnt++;
    for (int i = 0; i < NUM_RESULTS && i < issued.size() && i < popped.size(); i++) begin
      check_cnt++;
      if (issued[i] !== ADDR_W'(i) || popped[i] !== core_mem[i])
        $display("FAIL rmid_word%0d: got addr %0d data %0d want addr %0d data %0d", i, issued[i], popped[i], i, core_mem[i]);
      else pass_cnt++;
    end
    check_cnt++; if (checksum !== model_sum()) $display("FAIL rmid_checksum: got %0d want %0d", checksum, model_sum()); else pass_cnt++;
    end_drain();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NUM_RESULTS; i++) core_mem[i] = DATA_W'(511);
    delay_min = 1; delay_max = 1; ready_mode = 0;
    @(negedge clk); #1;
    clear_env();
    start_drain();
    wait_done("wrap", 200);
    check_cnt++; if (checksum !== CSUM_W'(8176)) $display("FAIL wrap_checksum: got %0d want 8176", checksum); else pass_cnt++;
    check_cnt++; if (popped.size() !== NUM_RESULTS) $display("FAIL wrap_word_count: got %0d want %0d", popped.size(), NUM_RESULTS); else pass_cnt++;
    end_drain();
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_spurious();
    test_backpressure();
    test_slow_core();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Downstream drain stage for the matrix core. On the rising edge of the core's `finish` flag it walks the core's result memory through the `read_n`/`r_addr`/`ry`/`data_out` read port. Each 9-bit result is buffered in a small FIFO and delivered on a valid/ready stream. The block keeps a running checksum and raises a completion pulse once every result has been handed off.

## Interface
- `NUM_RESULTS`, 16: number of result words to read, at addresses 0..NUM_RESULTS-1; must be ≤ 2^ADDR_W.
- `ADDR_W`, 8: core read-address width.
- `DATA_W`, 9: result word width.
- `FIFO_DEPTH`, 4: output buffer depth; must be a power of two, ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `finish_in` in 1: core ALU-done level; a 0→1 transition starts a drain.
- `read_n` out 1: active-low read strobe to the core.
- `r_addr` out ADDR_W: read address to the core.
- `ry` in 1: core read-ready; `data_in` is valid while `ry`=1.
- `data_in` in DATA_W: core read data.
- `out_data` out DATA_W: head of FIFO.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: sink accepts `out_data`.
- `busy` out 1: high from start until the drain is complete.
- `drain_done` out 1: one-cycle pulse on completion.
- `checksum` out DATA_W+$clog2(NUM_RESULTS): modular sum of all results captured in the current or most recent drain.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RY, FLUSH.
- **IDLE**
  - A rising edge of `finish_in` (registered compare of previous vs current) clears `idx` and `checksum`, sets `busy`, and moves to ISSUE.
  - Edges seen outside IDLE are ignored.
- **ISSUE**
  - If FIFO count < FIFO_DEPTH: drive `read_n`=0 with `r_addr`=`idx` for exactly one cycle, then go to WAIT_RY.
  - Otherwise stay in ISSUE with `read_n`=1 (back-pressure).
- **WAIT_RY**
  - `read_n`=1 and `r_addr` is held.
  - On `ry`=1: capture `data_in`, push it to the FIFO, add it to `checksum`, and increment `idx`.
  - Next state is ISSUE if `idx` was < NUM_RESULTS-1, else FLUSH.
  - `ry` is ignored in all other states.
- **FLUSH**
  - Waits for the FIFO to become empty.
  - The cycle the last pop completes: `drain_done`=1 for one cycle, `busy` drops, next state IDLE.
- **Outstanding reads:** exactly one read is in flight at a time. Space is checked at ISSUE, so a push never finds the FIFO full.
- **FIFO behaviour**
  - Show-ahead: `out_data` is valid whenever `out_valid`=1.
  - Pop when `out_valid`&&`out_ready`.
  - A push and a pop in the same cycle leave the count unchanged. A push into an empty FIFO appears on `out_valid` the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count is kept as a separate $clog2(FIFO_DEPTH)+1-bit register.
- **Checksum:** unsigned addition, wraps modulo 2^(DATA_W+$clog2(NUM_RESULTS)). It holds its value after completion until the next start.

## Timing
- **Reset values:** `read_n`=1, `r_addr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `drain_done`=0, `checksum`=0. The FIFO is flushed and the state is IDLE.
- **Reset mid-drain:** the drain is abandoned and not resumed. A new `finish_in` edge is required after reset; if `finish_in` is already high at reset release, no drain starts.
- **Start latency:** the `finish_in` rise is sampled at cycle T, `busy`=1 at T+1, and the first `read_n`=0 at T+1 (ISSUE entered at T+1).
- **Read timing:** `ry` must arrive ≥1 cycle after the `read_n` low cycle. With `ry` arriving the cycle after `read_n` low, one word is read every 2 cycles.
- **Minimum drain:** with `out_ready` held high, the minimum drain time is 2·NUM_RESULTS+2 cycles from `busy` rise to `drain_done`.

## Structure
- Package `result_drain_pkg`: state enum `drain_state_t` {IDLE, ISSUE, WAIT_RY, FLUSH} and localparam `CSUM_W` = DATA_W+$clog2(NUM_RESULTS).
- Sub-module `result_fifo`:
  - Parameters: DATA_W, DEPTH.
  - Ports: `push`, `push_data`, `pop`, `head`, `empty`, `full`, `count`.
  - Uses the same `clk`/`rst`.
- The FSM, address counter, edge detector and checksum live in `result_drain`.

## Test plan
- **Basic drain:** core model returns `data_in`=addr+3 one cycle after each read, `out_ready`=1, NUM_RESULTS=16 → 16 words 3..18 in order, `r_addr` 0..15, `checksum`=168, single `drain_done` pulse, `busy` low afterwards.
- **Back-pressure:** `out_ready`=0 for 20 cycles after start → exactly 4 reads issued (FIFO_DEPTH). After `out_ready` goes high, the remaining 12 are read, with no loss or duplication.
- **Slow core:** `ry` delayed 5 cycles per read → `read_n` low exactly one cycle per address, and `r_addr` stable until `ry`.
- **Spurious events:** `finish_in` toggles mid-drain and `ry` pulses while in IDLE → no restart, no extra FIFO entries, `checksum` unchanged.
- **Reset mid-drain:** `rst` asserted after 7 words captured → all outputs at reset values the next cycle. A new `finish_in` edge gives a full 16-word drain starting at address 0.
- **Wrap:** all results 511 with NUM_RESULTS=16 → `checksum`=8176 (13-bit, no overflow). A forced-overflow configuration wraps modulo 2^CSUM_W.
